control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 run  in  1  1 = advance T-states; 0 = pause.
REQ-005 lda, add, sub, xor_ratna, and_ratna, or_ratna, cmp_ratna, lda_imm, sta_imm, out  in  1 each  one-hot decoded opcode strobes.
REQ-006 low_halt  in  1  active-low halt strobe (0 = HLT).
REQ-007 cp, ep, lm, ce, li, ei, la, ea, lb, eu, wm, lo, lf  out  1 each  active-high control strobes:
- PC increment, PC enable, MAR load, RAM enable, IR load, IR-operand enable;
- A load, A enable, B load, ALU enable, RAM write, OUT load, flags load.
REQ-008 alu_op  out  3  ALU function: 000 add, 001 sub, 010 xor, 011 and, 100 or, 101 cmp.
REQ-009 t_state  out  6  one-hot ring state, bit0 = T1 ... bit5 = T6.
REQ-010 halted  out  1  sticky halt indicator.

Function
REQ-011 t_state is a registered one-hot ring: T1->T2->...->T6->T1, one step per clk while run=1, halted=0, rst=0.
REQ-012 run=0: t_state holds; all strobes and alu_op are 0 for that cycle; resumes in the held state when run returns to 1.
REQ-013 Strobes and alu_op are combinational from registered t_state plus the inputs. They are forced to 0 when rst=1, run=0 or halted=1.
REQ-014 Fetch, independent of inputs: T1 ep+lm; T2 cp; T3 ce+li.
REQ-015 Strobe inputs are valid only in T4-T6. They are ignored in T1-T3.
REQ-016 lda: T4 ei+lm; T5 ce+la; T6 none.
REQ-017 add/sub/xor_ratna/and_ratna/or_ratna: T4 ei+lm; T5 ce+lb; T6 eu+la with alu_op per REQ-008.
REQ-018 cmp_ratna: T4 ei+lm; T5 ce+lb; T6 eu+lf, alu_op=101, la=0.
REQ-019 lda_imm: T4 ei+la; T5, T6 none.
REQ-020 sta_imm: T4 ei+lm; T5 ea+wm; T6 none.
REQ-021 out: T4 ea+lo; T5, T6 none.
REQ-022 No strobe active and low_halt=1: NOP, T4-T6 all strobes 0.
REQ-023 Multiple strobes active: priority lda > add > sub > xor_ratna > and_ratna > or_ratna > cmp_ratna > lda_imm > sta_imm > out.
REQ-024 low_halt=0 in T4 overrides all strobes: no strobes in T4.
REQ-025 On the clk edge ending that T4 (run=1), halted<=1 and t_state<=000001.
REQ-026 halted=1: t_state frozen at 000001, strobes 0, run ignored; only rst clears it.
REQ-027 low_halt=0 in T1-T3 or T5-T6 has no effect.
REQ-028 alu_op is 000 whenever eu=0 and lf=0.
REQ-029 At most one of ep, ce, ei, ea, eu is 1 in any cycle (single bus driver).

Reset
REQ-030 rst=1 asynchronously sets t_state=000001 and halted=0. All strobes and alu_op are 0 while rst=1.
REQ-031 Reset mid-instruction abandons the instruction; the next cycle after release is T1 fetch.
REQ-032 On the first clk edge after rst falls, t_state remains 000001 for that cycle. T1 strobes (ep, lm) assert once rst=0 and run=1.

Verification
REQ-033 Reset, then run=1 with add=1 for 6 clocks -> per cycle: ep+lm / cp / ce+li / ei+lm / ce+lb / eu+la with alu_op=000; t_state returns to 000001.
REQ-034 cmp_ratna=1 through T6 -> eu=1, lf=1, la=0, alu_op=101; sta_imm=1 -> T5 ea=1, wm=1.
REQ-035 low_halt=0 at T4 -> T4 strobes all 0; after the edge halted=1 and t_state=000001. 20 further clocks with run toggling -> no change. rst pulse -> halted=0.
REQ-036 run=0 asserted in T3 for 3 clocks -> t_state stays 000100 with strobes 0. run=1 -> ce+li, then T4.
REQ-037 rst asserted asynchronously mid-T5 of lda -> t_state=000001 immediately, strobes 0. After release the fetch restarts at T1.
REQ-038 lda=1 and add=1 together -> lda sequence executes (T5 ce+la, T6 none); no strobes with opcode 1001 equivalent (all strobes 0, low_halt=1).

Source files
------------

// File: rtl/control_sequencer_if.sv
// Purpose: groups the sequencer's run/opcode/halt inputs and its control strobe outputs.
// Latency: none, this is wiring only; the timing belongs to the sequencer.
// Backpressure: none; run=0 is the only way to stall the sequencer.
interface control_sequencer_if;
    logic       run;
    logic       lda;
    logic       add;
    logic       sub;
    logic       xor_ratna;
    logic       and_ratna;
    logic       or_ratna;
    logic       cmp_ratna;
    logic       lda_imm;
    logic       sta_imm;
    logic       out;
    logic       low_halt;

    logic       cp;
    logic       ep;
    logic       lm;
    logic       ce;
    logic       li;
    logic       ei;
    logic       la;
    logic       ea;
    logic       lb;
    logic       eu;
    logic       wm;
    logic       lo;
    logic       lf;
    logic [2:0] alu_op;
    logic [5:0] t_state;
    logic       halted;

    // Drives run, the opcode strobes and low_halt, and watches the control strobes.
    modport master (
        output run, lda, add, sub, xor_ratna, and_ratna, or_ratna, cmp_ratna,
               lda_imm, sta_imm, out, low_halt,
        input  cp, ep, lm, ce, li, ei, la, ea, lb, eu, wm, lo, lf,
               alu_op, t_state, halted
    );

    // The sequencer side of the bundle.
    modport slave (
        input  run, lda, add, sub, xor_ratna, and_ratna, or_ratna, cmp_ratna,
               lda_imm, sta_imm, out, low_halt,
        output cp, ep, lm, ce, li, ei, la, ea, lb, eu, wm, lo, lf,
               alu_op, t_state, halted
    );
endinterface

// File: rtl/control_sequencer.sv
// Purpose: six-state T-ring microsequencer that emits datapath control strobes per decoded opcode.
// Latency: strobes are combinational from the registered T-state; the ring advances one step per clk.
// Backpressure: run=0 freezes the ring and blanks all strobes; a halt freezes everything until rst.
module control_sequencer (
    input  logic                clk,
    input  logic                rst,
    control_sequencer_if.slave  bus
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    typedef enum logic [3:0] {
        OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_XOR, OP_AND,
        OP_OR,  OP_CMP, OP_LDI, OP_STI, OP_OUT
    } op_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_CMP = 3'b101;

    t_state_e   t_state_q;
    t_state_e   t_state_d;
    logic       halted_q;
    logic       halted_d;
    op_e        op;
    logic       active;

    logic       cp, ep, lm, ce, li, ei, la, ea, lb, eu, wm, lo, lf;
    logic [2:0] alu_op;

    // T-state ring and sticky halt flag; reset puts the ring back at T1 and clears halt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_state_q <= T1;
            halted_q  <= 1'b0;
        end else begin
            t_state_q <= t_state_d;
            halted_q  <= halted_d;
        end
    end

    // Resolve simultaneous opcode strobes to one instruction, lda highest priority.
    always_comb begin
        op = OP_NOP;
        if      (bus.lda)       op = OP_LDA;
        else if (bus.add)       op = OP_ADD;
        else if (bus.sub)       op = OP_SUB;
        else if (bus.xor_ratna) op = OP_XOR;
        else if (bus.and_ratna) op = OP_AND;
        else if (bus.or_ratna)  op = OP_OR;
        else if (bus.cmp_ratna) op = OP_CMP;
        else if (bus.lda_imm)   op = OP_LDI;
        else if (bus.sta_imm)   op = OP_STI;
        else if (bus.out)       op = OP_OUT;
    end

    // Next T-state, halt capture and the control strobes for the current T-state.
    always_comb begin
        t_state_d = t_state_q;
        halted_d  = halted_q;
        cp = 1'b0; ep = 1'b0; lm = 1'b0; ce = 1'b0; li = 1'b0;
        ei = 1'b0; la = 1'b0; ea = 1'b0; lb = 1'b0; eu = 1'b0;
        wm = 1'b0; lo = 1'b0; lf = 1'b0;
        alu_op = ALU_ADD;

        // rst is included so strobes drop at once on an asynchronous reset.
        active = bus.run && !halted_q && !rst;

        if (active) begin
            // Halt is only sampled in T4, where it also suppresses the execute strobes.
            if (t_state_q == T4 && !bus.low_halt) begin
                halted_d  = 1'b1;
                t_state_d = T1;
            end else begin
                case (t_state_q)
                    T1:      t_state_d = T2;
                    T2:      t_state_d = T3;
                    T3:      t_state_d = T4;
                    T4:      t_state_d = T5;
                    T5:      t_state_d = T6;
                    default: t_state_d = T1;
                endcase
            end

            case (t_state_q)
                T1: begin
                    ep = 1'b1;
                    lm = 1'b1;
                end
                T2: cp = 1'b1;
                T3: begin
                    ce = 1'b1;
                    li = 1'b1;
                end
                T4: begin
                    if (bus.low_halt) begin
                        case (op)
                            OP_LDA, OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR, OP_CMP, OP_STI: begin
                                ei = 1'b1;
                                lm = 1'b1;
                            end
                            OP_LDI: begin
                                ei = 1'b1;
                                la = 1'b1;
                            end
                            OP_OUT: begin
                                ea = 1'b1;
                                lo = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                T5: begin
                    case (op)
                        OP_LDA: begin
                            ce = 1'b1;
                            la = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR, OP_CMP: begin
                            ce = 1'b1;
                            lb = 1'b1;
                        end
                        OP_STI: begin
                            ea = 1'b1;
                            wm = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    case (op)
                        OP_ADD: begin eu = 1'b1; la = 1'b1; alu_op = ALU_ADD; end
                        OP_SUB: begin eu = 1'b1; la = 1'b1; alu_op = ALU_SUB; end
                        OP_XOR: begin eu = 1'b1; la = 1'b1; alu_op = ALU_XOR; end
                        OP_AND: begin eu = 1'b1; la = 1'b1; alu_op = ALU_AND; end
                        OP_OR:  begin eu = 1'b1; la = 1'b1; alu_op = ALU_OR;  end
                        // Compare only updates flags; the accumulator is left untouched.
                        OP_CMP: begin eu = 1'b1; lf = 1'b1; alu_op = ALU_CMP; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.cp      = cp;
    assign bus.ep      = ep;
    assign bus.lm      = lm;
    assign bus.ce      = ce;
    assign bus.li      = li;
    assign bus.ei      = ei;
    assign bus.la      = la;
    assign bus.ea      = ea;
    assign bus.lb      = lb;
    assign bus.eu      = eu;
    assign bus.wm      = wm;
    assign bus.lo      = lo;
    assign bus.lf      = lf;
    assign bus.alu_op  = alu_op;
    assign bus.t_state = t_state_q;
    assign bus.halted  = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Purpose: scoreboard bench for control_sequencer against a step-counter reference model.
// Latency: one expectation per clk cycle, compared at the falling edge of that cycle.
// Backpressure: exercises run=0 stalls, halt and asynchronous reset.
module tb_control_sequencer;

    // Bit positions of the packed strobe vector {cp,ep,lm,ce,li,ei,la,ea,lb,eu,wm,lo,lf}.
    localparam logic [12:0] S_CP = 13'b1 << 12;
    localparam logic [12:0] S_EP = 13'b1 << 11;
    localparam logic [12:0] S_LM = 13'b1 << 10;
    localparam logic [12:0] S_CE = 13'b1 << 9;
    localparam logic [12:0] S_LI = 13'b1 << 8;
    localparam logic [12:0] S_EI = 13'b1 << 7;
    localparam logic [12:0] S_LA = 13'b1 << 6;
    localparam logic [12:0] S_EA = 13'b1 << 5;
    localparam logic [12:0] S_LB = 13'b1 << 4;
    localparam logic [12:0] S_EU = 13'b1 << 3;
    localparam logic [12:0] S_WM = 13'b1 << 2;
    localparam logic [12:0] S_LO = 13'b1 << 1;
    localparam logic [12:0] S_LF = 13'b1;

    // Opcode vectors, bit0 = lda ... bit9 = out (priority order).
    localparam logic [9:0] O_NOP = 10'd0;
    localparam logic [9:0] O_LDA = 10'b1 << 0;
    localparam logic [9:0] O_ADD = 10'b1 << 1;
    localparam logic [9:0] O_CMP = 10'b1 << 6;
    localparam logic [9:0] O_STA = 10'b1 << 8;

    logic clk;
    logic rst;
    control_sequencer_if sif();

    control_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [22:0] exp_q[$];
    string       tag_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          stim_done = 1'b0;

    // Reference model: step 1..6 and a halted bit.
    int m_step = 1;
    bit m_halted = 1'b0;

    function automatic logic [22:0] model_out(int step, bit halted, bit r, bit run,
                                              logic [9:0] ops, bit low_halt);
        logic [12:0] s;
        logic [2:0]  a;
        logic [5:0]  t;
        int          op;
        s  = '0;
        a  = '0;
        op = -1;
        if (!r && run && !halted) begin
            for (int i = 0; i < 10; i++)
                if (ops[i] && op < 0) op = i;
            case (step)
                1: s = S_EP | S_LM;
                2: s = S_CP;
                3: s = S_CE | S_LI;
                4: if (low_halt) begin
                       if (op inside {[0:6], 8}) s = S_EI | S_LM;
                       else if (op == 7)         s = S_EI | S_LA;
                       else if (op == 9)         s = S_EA | S_LO;
                   end
                5: begin
                       if (op == 0)                s = S_CE | S_LA;
                       else if (op inside {[1:6]}) s = S_CE | S_LB;
                       else if (op == 8)           s = S_EA | S_WM;
                   end
                6: begin
                       if (op inside {[1:5]}) begin
                           s = S_EU | S_LA;
                           a = 3'(op - 1);
                       end else if (op == 6) begin
                           s = S_EU | S_LF;
                           a = 3'd5;
                       end
                   end
                default: ;
            endcase
        end
        t = 6'(1 << (step - 1));
        return {t, halted, a, s};
    endfunction

    task automatic drive(string tag, bit r, bit run, logic [9:0] ops, bit low_halt);
        rst          = r;
        sif.run      = run;
        {sif.out, sif.sta_imm, sif.lda_imm, sif.cmp_ratna, sif.or_ratna,
         sif.and_ratna, sif.xor_ratna, sif.sub, sif.add, sif.lda} = ops;
        sif.low_halt = low_halt;
        if (r) begin
            m_step   = 1;
            m_halted = 1'b0;
        end
        exp_q.push_back(model_out(m_step, m_halted, r, run, ops, low_halt));
        tag_q.push_back(tag);
        @(posedge clk);
        if (!r && !m_halted && run) begin
            if (m_step == 4 && !low_halt) begin
                m_halted = 1'b1;
                m_step   = 1;
            end else begin
                m_step = (m_step % 6) + 1;
            end
        end
        #1;
    endtask

    function automatic logic [9:0] rand_ops();
        int k;
        k = $urandom_range(0, 3);
        if (k == 0) return O_NOP;
        if (k == 1) return 10'(1 << $urandom_range(0, 9));
        return 10'($urandom);
    endfunction

    // Monitor: compares every cycle's outputs with the queued expectation and prints the summary.
    initial begin
        logic [22:0] got;
        logic [22:0] exp;
        string       tag;
        int          cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                tag = tag_q.pop_front();
                got = {sif.t_state, sif.halted, sif.alu_op,
                       sif.cp, sif.ep, sif.lm, sif.ce, sif.li, sif.ei, sif.la,
                       sif.ea, sif.lb, sif.eu, sif.wm, sif.lo, sif.lf};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL %s: got t_state=%b halted=%b alu_op=%b strobes=%b, expected t_state=%b halted=%b alu_op=%b strobes=%b",
                             tag, got[22:17], got[16], got[15:13], got[12:0],
                             exp[22:17], exp[16], exp[15:13], exp[12:0]);
                end
            end else if (stim_done) begin
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
            if (cyc > 20000) begin
                errors++;
                $display("FAIL watchdog: cycle budget exhausted, queue depth %0d, required 0", exp_q.size());
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    // Stimulus: directed scenarios first, then a randomized run.
    initial begin
        rst = 1'b1;
        sif.run = 1'b0;
        {sif.out, sif.sta_imm, sif.lda_imm, sif.cmp_ratna, sif.or_ratna,
         sif.and_ratna, sif.xor_ratna, sif.sub, sif.add, sif.lda} = '0;
        sif.low_halt = 1'b1;
        @(posedge clk);
        #1;

        repeat (2) drive("reset", 1, 1, O_ADD, 1);

        // add instruction through all six T-states, then back at T1
        repeat (6) drive("add_seq", 0, 1, O_ADD, 1);
        repeat (6) drive("cmp_seq", 0, 1, O_CMP, 1);
        repeat (6) drive("sta_seq", 0, 1, O_STA, 1);

        // stall in T3
        repeat (2) drive("pre_stall", 0, 1, O_NOP, 1);
        repeat (3) drive("stall_t3", 0, 0, O_ADD, 1);
        repeat (4) drive("post_stall", 0, 1, O_NOP, 1);

        // priority lda over add, then a NOP
        repeat (6) drive("lda_prio", 0, 1, O_LDA | O_ADD, 1);
        repeat (6) drive("nop_seq", 0, 1, O_NOP, 1);

        // reset during T5 of lda, then a fresh fetch
        repeat (4) drive("lda_pre_rst", 0, 1, O_LDA, 1);
        drive("rst_mid_t5", 1, 1, O_LDA, 1);
        drive("rst_hold", 1, 1, O_LDA, 1);
        repeat (6) drive("lda_after_rst", 0, 1, O_LDA, 1);

        // halt in T4 overrides the opcode, then stays sticky
        repeat (3) drive("pre_halt", 0, 1, O_NOP, 0);
        drive("halt_t4", 0, 1, O_ADD, 0);
        for (int i = 0; i < 20; i++)
            drive("halted_hold", 0, i[0], rand_ops(), 1'($urandom_range(0, 1)));
        drive("halt_clear", 1, 1, O_NOP, 1);
        repeat (6) drive("after_halt", 0, 1, O_ADD, 1);

        // randomized traffic
        for (int i = 0; i < 600; i++)
            drive("random", ($urandom_range(0, 39) == 0), ($urandom_range(0, 6) != 0),
                  rand_ops(), ($urandom_range(0, 19) != 0));

        stim_done = 1'b1;
    end

endmodule
